log_seq_ctrl: RTL and testbench

//  Acquisition sequencer for the data logger. Sits between the UART command receiver (24-bit start_adr/stop_adr/status
//  + pkt_done) and the external sample memory. Walks a write pointer from start_adr to stop_adr, one byte per sample

---
 rtl/log_pkg.sv | 12 +
 rtl/log_tmo_cnt.sv | 18 +
 rtl/log_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_log_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// log_pkg: shared encodings for the data-logger acquisition sequencer.
package log_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_SMP, WR, ERASE, FIN} state_t;
    localparam logic [1:0] CMD_ABORT = 2'b00;
    localparam logic [1:0] CMD_REC   = 2'b01;
    localparam logic [1:0] CMD_ERASE = 2'b10;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_OVR   = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;
    localparam logic [7:0] ERASE_BYTE = 8'hFF;
endpackage

// File: rtl/log_tmo_cnt.sv
// log_tmo_cnt: counts stalled request cycles; tmo marks the TMO_CYC-th consecutive stall.
module log_tmo_cnt #(
    parameter int TMO_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tmo
);
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt;
    assign tmo = en && (cnt == CW'(TMO_CYC - 1));
    always_ff @(posedge clk) begin
        if (!reset || clr || !en) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/log_seq_ctrl.sv
// log_seq_ctrl: walks a write pointer from start_adr to stop_adr, one memory write per sample or erase byte.
// Build option LOG_SEQ_WRAP_EN makes record mode circular (reload start at stop, pulse done, keep running).
module log_seq_ctrl
    import log_pkg::*;
#(
    parameter int AW      = 24,
    parameter int DW      = 8,
    parameter int TMO_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pkt_done,
    input  logic [AW-1:0] start_adr,
    input  logic [AW-1:0] stop_adr,
    input  logic [AW-1:0] status,
    input  logic          smp_valid,
    input  logic [DW-1:0] smp_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n, stop, stop_n;
    logic [DW-1:0] wdata_n;
    logic [1:0] cmd, err_n;
    logic req_n, busy_n, done_n, xfer, tmo, abort, unused_ok;
    assign cmd = status[1:0];
    assign unused_ok = &{1'b0, status[AW-1:2]};
    assign xfer = mem_req & mem_ready;
    assign abort = pkt_done && (cmd == CMD_ABORT) && (state != IDLE);
    assign mem_adr = ptr;
    log_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk(clk), .reset(reset), .clr(xfer), .en(mem_req & ~mem_ready), .tmo(tmo)
    );
`ifdef LOG_SEQ_WRAP_EN
    logic [AW-1:0] start_q;
    always_ff @(posedge clk) begin
        if (!reset) start_q <= '0;
        else if (state == IDLE && pkt_done) start_q <= start_adr;
    end
`endif
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        stop_n  = stop;
        wdata_n = mem_wdata;
        req_n   = mem_req;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err;
        case (state)
            IDLE: if (pkt_done && (cmd == CMD_REC || cmd == CMD_ERASE)) begin
                if (start_adr <= stop_adr) begin
                    ptr_n   = start_adr;
                    stop_n  = stop_adr;
                    err_n   = ERR_NONE;
                    busy_n  = 1'b1;
                    req_n   = (cmd == CMD_ERASE);
                    wdata_n = (cmd == CMD_ERASE) ? DW'(ERASE_BYTE) : mem_wdata;
                    state_n = (cmd == CMD_REC) ? WAIT_SMP : ERASE;
                end else err_n = ERR_RANGE;
            end
            WAIT_SMP: if (smp_valid) begin
                wdata_n = smp_data;
                req_n   = 1'b1;
                state_n = WR;
            end
            WR, ERASE: if (xfer) begin
                // erase streams back-to-back; record waits for the next sample
                req_n   = (state == ERASE);
                ptr_n   = ptr + 1'b1;
                state_n = (state == ERASE) ? ERASE : WAIT_SMP;
                if (ptr == stop) begin
                    done_n = 1'b1;
`ifdef LOG_SEQ_WRAP_EN
                    if (state == WR) ptr_n = start_q;
                    else
`endif
                    begin
                        req_n   = 1'b0;
                        busy_n  = 1'b0;
                        state_n = FIN;
                    end
                end
            end else begin
                if (state == WR && smp_valid) err_n = ERR_OVR;
                if (tmo) begin
                    err_n   = ERR_TMO;
                    req_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort wins over everything, including a transfer completing this cycle
        if (abort) begin
            req_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            stop      <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_NONE;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            stop      <= stop_n;
            mem_wdata <= wdata_n;
            mem_req   <= req_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_log_seq_ctrl.sv
// tb_log_seq_ctrl: directed bench with a write scoreboard and per-cycle handshake checks for log_seq_ctrl.
module tb_log_seq_ctrl;
    logic clk = 0, reset = 0, pkt_done = 0, smp_valid = 0, mem_ready = 0;
    logic [23:0] start_adr = '0, stop_adr = '0, status = '0, mem_adr;
    logic [7:0] smp_data = '0, mem_wdata;
    logic mem_req, busy, done;
    logic [1:0] err;
    int n_vec = 0, n_bad = 0, done_seen = 0, exp_done = 0;
    bit chk_on = 0;
    logic [31:0] exp_q[$];
    logic p_req = 0, p_rdy = 0, p_done = 0;
    logic [23:0] p_adr = '0;
    logic [7:0] p_wd = '0;
    logic [31:0] w;

    always #5 clk = ~clk;

    log_seq_ctrl dut (
        .clk(clk), .reset(reset), .pkt_done(pkt_done), .start_adr(start_adr), .stop_adr(stop_adr),
        .status(status), .smp_valid(smp_valid), .smp_data(smp_data), .mem_req(mem_req),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // every accepted write must be the next {adr,data} the bench predicted
    always @(negedge clk) if (chk_on) begin
        if (mem_req && mem_ready) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("write_adr", 32'(mem_adr), 32'(w[31:8]));
                chk("write_data", 32'(mem_wdata), 32'(w[7:0]));
            end
        end
        if (mem_req && p_req && !p_rdy) begin
            chk("hold_adr", 32'(mem_adr), 32'(p_adr));
            chk("hold_data", 32'(mem_wdata), 32'(p_wd));
        end
        chk("req_implies_busy", 32'(mem_req & ~busy), 32'd0);
        chk("done_single_cycle", 32'(done & p_done), 32'd0);
        if (done) done_seen++;
        p_req = mem_req;
        p_rdy = mem_ready;
        p_done = done;
        p_adr = mem_adr;
        p_wd = mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [23:0] s, input logic [23:0] e);
        pkt_done = 1;
        status = {22'd0, c};
        start_adr = s;
        stop_adr = e;
        tick();
        pkt_done = 0;
    endtask

    task automatic smp(input logic [7:0] d);
        smp_valid = 1;
        smp_data = d;
        tick();
        smp_valid = 0;
    endtask

    task automatic expect_wr(input logic [23:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        int n;
        repeat (2) tick();
        chk_on = 1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_adr", 32'(mem_adr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        reset = 1;
        tick();

        // record 0x10..0x12 with an always-ready memory
        mem_ready = 1;
        for (int i = 0; i < 3; i++) expect_wr(24'h10 + 24'(i), 8'hA1 + 8'(i));
        send(2'b01, 24'h10, 24'h12);
        chk("rec_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            smp(8'hA1 + 8'(i));
            tick();
        end
        exp_done++;
        chk("rec_done", 32'(done), 1);
        chk("rec_busy_fall", 32'(busy), 0);
        tick();
        chk("rec_done_low", 32'(done), 0);
        chk("rec_err", 32'(err), 0);

        // reversed range
        send(2'b01, 24'h20, 24'h1F);
        chk("range_err", 32'(err), 1);
        chk("range_busy", 32'(busy), 0);
        tick();
        chk("range_req", 32'(mem_req), 0);

        // overrun: second sample arrives while the first write stalls
        mem_ready = 0;
        expect_wr(24'h30, 8'h55);
        expect_wr(24'h31, 8'h77);
        send(2'b01, 24'h30, 24'h31);
        chk("ovr_err_cleared", 32'(err), 0);
        smp(8'h55);
        tick();
        smp(8'h66);
        chk("ovr_err", 32'(err), 2);
        tick();
        tick();
        chk("ovr_req_held", 32'(mem_req), 1);
        chk("ovr_adr_held", 32'(mem_adr), 32'h30);
        chk("ovr_data_held", 32'(mem_wdata), 32'h55);
        mem_ready = 1;
        tick();
        chk("ovr_req_drop", 32'(mem_req), 0);
        smp(8'h77);
        tick();
        exp_done++;
        chk("ovr_done", 32'(done), 1);
        chk("ovr_err_sticky", 32'(err), 2);
        tick();

        // erase 0x100..0x103 back-to-back
        for (int i = 0; i < 4; i++) expect_wr(24'h100 + 24'(i), 8'hFF);
        send(2'b10, 24'h100, 24'h103);
        chk("era_err_cleared", 32'(err), 0);
        chk("era_req", 32'(mem_req), 1);
        chk("era_adr", 32'(mem_adr), 32'h100);
        chk("era_data", 32'(mem_wdata), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("era_req_cont", 32'(mem_req), 1);
        end
        tick();
        exp_done++;
        chk("era_done", 32'(done), 1);
        tick();

        // top-of-space erase ends without wrapping
        expect_wr(24'hFFFFFE, 8'hFF);
        expect_wr(24'hFFFFFF, 8'hFF);
        send(2'b10, 24'hFFFFFE, 24'hFFFFFF);
        tick();
        tick();
        exp_done++;
        chk("top_done", 32'(done), 1);
        chk("top_busy", 32'(busy), 0);
        tick();
        chk("top_no_wrap", 32'(mem_req), 0);

        // start == stop gives exactly one write
        expect_wr(24'h400, 8'hFF);
        send(2'b10, 24'h400, 24'h400);
        tick();
        exp_done++;
        chk("one_done", 32'(done), 1);
        tick();

        // stuck memory times out after TMO_CYC stalled cycles
        mem_ready = 0;
        send(2'b01, 24'h200, 24'h205);
        smp(8'h99);
        n = 1;
        while (mem_req && n < 5000) begin
            tick();
            if (mem_req) n++;
        end
        chk("tmo_cycles", 32'(n), 4096);
        chk("tmo_err", 32'(err), 3);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_no_done", 32'(done_seen), 32'(exp_done));

        // reserved command in IDLE is ignored
        send(2'b11, 24'h0, 24'h5);
        tick();
        chk("rsvd_busy", 32'(busy), 0);
        chk("rsvd_err", 32'(err), 3);

        // abort with a pending request
        send(2'b01, 24'h300, 24'h305);
        chk("abt_err_cleared", 32'(err), 0);
        smp(8'h42);
        chk("abt_req_before", 32'(mem_req), 1);
        send(2'b00, 24'h0, 24'h0);
        chk("abt_req", 32'(mem_req), 0);
        chk("abt_busy", 32'(busy), 0);
        tick();
        tick();
        chk("abt_idle_req", 32'(mem_req), 0);

        chk("done_count", 32'(done_seen), 32'(exp_done));
        chk("pending_writes", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
